// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_DEF = 16;
    localparam int CNT_W = $clog2(N_DEF);

endpackage

// File: rtl/mul_seq.sv
// Fixed-latency N x N unsigned shift-and-add multiplier: IDLE -> RUN (N cycles) -> DONE.
// Handshake: start is sampled only in IDLE; busy high means start is dropped; P_valid is a one-cycle pulse.
module mul_seq
    import mul_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   Anum_reg,
    input  logic [N-1:0]   Bnum_reg,
    output logic [2*N-1:0] P_reg,
    output logic           P_valid,
    output logic           busy,
    output state_e         dbg_state
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e         state_q, state_d;
    logic [2*N-1:0] a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] p_reg_q, p_reg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_reg_q <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_reg_q <= p_reg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_reg_d = p_reg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = {{N{1'b0}}, Anum_reg};
                    b_sh_d  = Bnum_reg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (b_sh_q[0]) begin
                    acc_d = acc_q + a_sh_q;
                end
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                // Last iteration: the product register takes the final sum so it is visible in DONE.
                if (cnt_q == CW'(N - 1)) begin
                    p_reg_d = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign P_reg     = p_reg_q;
    assign P_valid   = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and streaming checks of mul_seq: latency, products, start-while-busy, reset abort.
module tb_mul_seq;
    import mul_pkg::*;

    localparam int N = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  anum;
    logic [N-1:0]  bnum;
    logic [2*N-1:0] p_reg;
    logic          p_valid;
    logic          busy;
    state_e        dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*N-1:0] exp_q[$];

    mul_seq #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Anum_reg (anum),
        .Bnum_reg (bnum),
        .P_reg    (p_reg),
        .P_valid  (p_valid),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: present operands with start for one edge, then scramble operands
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        start = 1'b1;
        anum  = a;
        bnum  = b;
        step();
        start = 1'b0;
        anum  = N'($urandom_range(0, 65535));
        bnum  = N'($urandom_range(0, 65535));
    endtask

    // Observe cycles k+1 .. k+18; optionally pulse start (A=2,B=2) on one RUN cycle.
    task automatic watch(input logic [2*N-1:0] expv, input string tag, input int pulse_at);
        int lat = 0;
        int nv  = 0;
        int nb  = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            if (p_valid) begin
                nv++;
                lat = cyc;
                chk({tag, "_prod"}, p_reg, expv);
            end
            if (busy) nb++;
            if (cyc == pulse_at) begin
                start = 1'b1;
                anum  = 16'd2;
                bnum  = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (cyc < 18) step();
        end
        chk({tag, "_latency"}, lat, 17);
        chk({tag, "_nvalid"}, nv, 1);
        chk({tag, "_busy_cycles"}, nb, 17);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int nv;
        int phase;
        int pushed;
        int popped;
        int guard;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2*N-1:0] e;

        rst   = 1'b1;
        start = 1'b0;
        anum  = '0;
        bnum  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_p_reg", p_reg, 0);
        chk("rst_p_valid", p_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, IDLE);
        step();
        chk("idle_hold_busy", busy, 0);

        issue(16'd3, 16'd5);
        watch(32'h0000_000F, "mul_3x5", 0);
        repeat (3) step();
        chk("hold_p_reg", p_reg, 32'h0000_000F);
        chk("hold_p_valid", p_valid, 0);

        issue(16'hFFFF, 16'hFFFF);
        watch(32'hFFFE_0001, "mul_ffff", 0);
        issue(16'h8000, 16'h0002);
        watch(32'h0001_0000, "mul_8000x2", 0);
        issue(16'h0000, 16'h1234);
        watch(32'h0000_0000, "mul_0xb", 0);
        issue(16'h1234, 16'h0000);
        watch(32'h0000_0000, "mul_ax0", 0);

        // start pulse during RUN is ignored; next start right on the IDLE cycle after DONE
        issue(16'd7, 16'd9);
        watch(32'h0000_003F, "mul_7x9_busy_start", 5);
        issue(16'd2, 16'd2);
        watch(32'h0000_0004, "mul_2x2_back2back", 0);

        // reset during cycle k+8 aborts the operation
        issue(16'd100, 16'd100);
        repeat (7) step();
        chk("abort_busy_before", busy, 1);
        chk("abort_p_reg_before", p_reg, 32'h0000_0004);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_p_valid", p_valid, 0);
        chk("abort_p_reg", p_reg, 0);
        chk("abort_state", dbg_state, IDLE);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            if (p_valid) nv++;
            step();
        end
        chk("abort_no_valid", nv, 0);
        issue(16'd10, 16'd10);
        watch(32'd100, "mul_10x10", 0);

        // scoreboard: start held high, operands change every cycle
        phase  = 0;
        pushed = 0;
        popped = 0;
        guard  = 0;
        while ((pushed < 1000 || phase != 0) && guard < 30000) begin
            chk("stream_valid_timing", p_valid, (phase == 17));
            if (p_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("stream_prod", p_reg, e);
                    popped++;
                end else begin
                    chk("stream_queue_empty", exp_q.size(), 1);
                end
            end
            ra   = 32'($urandom_range(0, 65535));
            rb   = 32'($urandom_range(0, 65535));
            anum = ra[N-1:0];
            bnum = rb[N-1:0];
            start = (pushed < 1000);
            if (phase == 0) begin
                if (pushed < 1000) begin
                    exp_q.push_back(ra * rb);
                    pushed++;
                    phase = 1;
                end
            end else if (phase == 17) begin
                phase = 0;
            end else begin
                phase++;
            end
            step();
            guard++;
        end
        start = 1'b0;
        chk("stream_popped", popped, 1000);
        chk("stream_queue_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 16×16 unsigned shift-and-add multiplier. It is the inverse-direction companion to the team's restoring divider in the UART calculator datapath. Operands arrive from the UART command parser, and a start pulse launches a fixed-latency multiply. The 32-bit product is returned with a one-cycle valid pulse for the UART transmit formatter.

## Interface
- N, default 16: operand width; product width is 2N.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Anum_reg  input  N  multiplicand; sampled on the accepted start edge.
- Bnum_reg  input  N  multiplier; sampled on the accepted start edge.
- P_reg  output  2N  product register; holds the last result until the next completion.
- P_valid  output  1  one-cycle pulse when P_reg has just been updated.
- busy  output  1  high in RUN and DONE; high means start is ignored.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: N iteration cycles.
  - DONE: one cycle, result presented.
- IDLE, start=1:
  - A_sh ← zero-extended Anum_reg (2N bits).
  - B_sh ← Bnum_reg.
  - acc ← 0, cnt ← 0.
  - Go to RUN.
- IDLE, start=0: remain in IDLE; no register changes.
- RUN, every cycle:
  - If B_sh[0]: acc ← acc + A_sh (2N-bit add; cannot overflow).
  - A_sh ← A_sh << 1.
  - B_sh ← B_sh >> 1.
  - cnt ← cnt + 1.
  - When cnt == N−1, this is the last iteration: go to DONE.
- DONE:
  - P_reg ← final acc, loaded at the RUN→DONE edge so it is visible in DONE.
  - P_valid = 1.
  - Unconditionally return to IDLE on the next edge.
- No early termination: latency is fixed even when operands are zero.
- start while busy: ignored, not queued. Operand inputs are don't-care after acceptance.
- Arithmetic is unsigned only. cnt width is ceil(log2 N) bits.

## Timing
- Reset values: state=IDLE, P_reg=0, P_valid=0, busy=0, acc=0, cnt=0.
- Cycle numbering: start accepted at edge k.
  - busy rises after edge k.
  - RUN occupies cycles k+1 … k+N.
  - DONE is cycle k+N+1, with P_valid=1 and P_reg valid.
  - busy falls after edge k+N+1.
- Latency from start edge to P_valid is N+1 cycles (17 for N=16).
- Minimum issue interval is N+2 cycles. Start may be asserted on the IDLE cycle right after DONE.
- start held high continuously: a new operation is accepted each time IDLE is reached, using the operands present at that edge.
- rst asserted mid-RUN or in DONE:
  - Abort immediately at that edge: IDLE, P_reg=0, P_valid=0, busy=0.
  - No P_valid is produced for the aborted operation.
- rst and start together: rst wins.
- P_valid is registered (state decode of DONE) and never glitches.

## Structure
- Shared package `mul_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Default N.
  - Localparam CNT_W = $clog2(N).
- Single module. The datapath (one adder, two shifters) is too small to justify a sub-module. FSM and datapath live together.

## Test plan
- Reset, then start with A=3, B=5:
  - P_valid exactly 17 cycles after the start edge.
  - P_reg=0x0000000F.
  - busy high for 17 cycles.
- A=0xFFFF, B=0xFFFF → P_reg=0xFFFE0001. Also A=0x8000, B=0x0002 → 0x00010000.
- A=0, B=0x1234 and A=0x1234, B=0 → P_reg=0, still with 17-cycle latency.
- Start A=7, B=9, then pulse start with A=2, B=2 during RUN → single P_valid, P_reg=0x3F. Start on the following IDLE cycle with A=2, B=2 → P_reg=4 a further 17 cycles later.
- Assert rst during cycle k+8 of A=100, B=100 → P_valid never pulses; P_reg=0; busy=0 next cycle. A subsequent start with A=10, B=10 → P_reg=100.
- start held high with operands changing every cycle: each product matches the operands at its accepted edge, with issue interval 18 cycles. Compare against a reference model over 1000 random operand pairs.
